// File: rtl/twiddle_sequencer_if.sv
// Bundles the sample-in stream, the multiplier issue/result bus and the sample-out stream
// of the twiddle sequencer. The master modport is the sequencer; slave is its surroundings.
interface twiddle_sequencer_if;
    logic        [5:0]  cfg_step;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_re;
    logic signed [15:0] in_im;

    logic               cm_isValid;
    logic        [5:0]  cm_start;
    logic        [5:0]  cm_step;
    logic signed [15:0] cm_x  [0:7];
    logic signed [15:0] cm_xi [0:7];
    logic               cm_resultValid;
    logic signed [15:0] cm_y  [0:7];
    logic signed [15:0] cm_yi [0:7];

    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;
    logic               frame_done;
    logic               err;

    modport master (
        input  cfg_step, in_valid, in_re, in_im,
        input  cm_resultValid, cm_y, cm_yi,
        input  out_ready,
        output in_ready,
        output cm_isValid, cm_start, cm_step, cm_x, cm_xi,
        output out_valid, out_re, out_im, frame_done, err
    );

    modport slave (
        output cfg_step, in_valid, in_re, in_im,
        output cm_resultValid, cm_y, cm_yi,
        output out_ready,
        input  in_ready,
        input  cm_isValid, cm_start, cm_step, cm_x, cm_xi,
        input  out_valid, out_re, out_im, frame_done, err
    );
endinterface

// File: rtl/twiddle_sequencer.sv
// Packs serial complex samples into 8-lane blocks, issues them to the twiddle multiplier,
// and streams the products back out, with frame counting and a WAIT timeout.
//
//  state | meaning
//  FILL  | accepting input samples into lane buffer slots 0..7
//  ISSUE | one-cycle cm_isValid strobe with start index and step
//  WAIT  | lanes held for the multiplier; result strobe or timeout
//  DRAIN | serial output of the 8 captured products
module twiddle_sequencer #(
    parameter int NUM_BLOCKS = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    twiddle_sequencer_if.master  bus
);
    localparam int         WCW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [5:0] LAST_BLOCK = 6'(NUM_BLOCKS - 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {FILL, ISSUE, WAIT, DRAIN} state_t;

    state_t             state;
    logic [2:0]         lane_idx;
    logic [2:0]         out_idx;
    logic [5:0]         block_idx;
    logic [WCW-1:0]     wait_cnt;
    logic [5:0]         step_reg;
    logic signed [15:0] obuf_re [0:7];
    logic signed [15:0] obuf_im [0:7];
    logic [2:0]         idx_prod;

    // Only the low 3 bits of block_idx*step survive the <<3 and mod-64 wrap.
    assign idx_prod = block_idx[2:0] * step_reg[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= FILL;
            lane_idx       <= '0;
            out_idx        <= '0;
            block_idx      <= '0;
            wait_cnt       <= '0;
            step_reg       <= '0;
            bus.in_ready   <= 1'b0;
            bus.cm_isValid <= 1'b0;
            bus.cm_start   <= '0;
            bus.cm_step    <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_re     <= '0;
            bus.out_im     <= '0;
            bus.frame_done <= 1'b0;
            bus.err        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                bus.cm_x[i]  <= '0;
                bus.cm_xi[i] <= '0;
                obuf_re[i]   <= '0;
                obuf_im[i]   <= '0;
            end
        end else begin
            bus.cm_isValid <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                FILL: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        // The lane buffer doubles as the multiplier operand register.
                        bus.cm_x[lane_idx]  <= bus.in_re;
                        bus.cm_xi[lane_idx] <= bus.in_im;
                        if (block_idx == 6'd0 && lane_idx == 3'd0)
                            step_reg <= bus.cfg_step;
                        if (lane_idx == 3'd7) begin
                            lane_idx       <= '0;
                            bus.in_ready   <= 1'b0;
                            bus.cm_isValid <= 1'b1;
                            bus.cm_step    <= step_reg;
                            bus.cm_start   <= {idx_prod, 3'b000};
                            state          <= ISSUE;
                        end else begin
                            lane_idx <= lane_idx + 3'd1;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (bus.cm_resultValid) begin
                        for (int i = 0; i < 8; i++) begin
                            obuf_re[i] <= bus.cm_y[i];
                            obuf_im[i] <= bus.cm_yi[i];
                        end
                        bus.out_re    <= bus.cm_y[0];
                        bus.out_im    <= bus.cm_yi[0];
                        bus.out_valid <= 1'b1;
                        out_idx       <= '0;
                        wait_cnt      <= '0;
                        state         <= DRAIN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Abandon the block; block_idx stays so the retry reuses cm_start.
                        bus.err      <= 1'b1;
                        wait_cnt     <= '0;
                        lane_idx     <= '0;
                        bus.in_ready <= 1'b1;
                        state        <= FILL;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.out_valid && bus.out_ready) begin
                        if (out_idx == 3'd7) begin
                            out_idx       <= '0;
                            bus.out_valid <= 1'b0;
                            bus.in_ready  <= 1'b1;
                            state         <= FILL;
                            if (block_idx == LAST_BLOCK) begin
                                block_idx      <= '0;
                                bus.frame_done <= 1'b1;
                            end else begin
                                block_idx <= block_idx + 6'd1;
                            end
                        end else begin
                            out_idx    <= out_idx + 3'd1;
                            bus.out_re <= obuf_re[out_idx + 3'd1];
                            bus.out_im <= obuf_im[out_idx + 3'd1];
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_twiddle_sequencer.sv
// Directed bench for twiddle_sequencer: framing, start-index wrap, step latch,
// back-pressure, timeout, spurious result strobes and mid-drain reset.
module tb_twiddle_sequencer;
    localparam int NB = 8;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic               mul_en = 1'b1;
    logic               mul_rv = 1'b0;
    logic               spur   = 1'b0;
    logic signed [15:0] y_reg  [0:7];
    logic signed [15:0] yi_reg [0:7];

    twiddle_sequencer_if bus ();

    twiddle_sequencer #(.NUM_BLOCKS(NB), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One-cycle registered multiplier stand-in: y = x + 100, yi = xi - 100.
    always @(posedge clk) begin
        mul_rv <= bus.cm_isValid && mul_en;
        if (bus.cm_isValid) begin
            for (int i = 0; i < 8; i++) begin
                y_reg[i]  <= bus.cm_x[i] + 16'sd100;
                yi_reg[i] <= bus.cm_xi[i] - 16'sd100;
            end
        end
    end

    assign bus.cm_resultValid = mul_rv | spur;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            bus.cm_y[i]  = spur ? 16'sh7777 : y_reg[i];
            bus.cm_yi[i] = spur ? 16'sh7777 : yi_reg[i];
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int base, input int exp_start, input int exp_step);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("fill_ready", 32'(bus.in_ready), 1);
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_re    = 16'(base + k);
            bus.in_im    = 16'(-(base + k));
            spur         = (k == 3);
            tick();
        end
        spur         = 1'b0;
        bus.in_valid = 1'b0;
        check("issue_valid", 32'(bus.cm_isValid), 1);
        check("cm_start", 32'(bus.cm_start), exp_start);
        check("cm_step", 32'(bus.cm_step), exp_step);
        check("cm_x5", bus.cm_x[5], base + 5);
        check("cm_xi2", bus.cm_xi[2], -(base + 2));
        check("issue_in_ready", 32'(bus.in_ready), 0);
        tick();
        check("issue_one_cycle", 32'(bus.cm_isValid), 0);
        check("wait_out_valid", 32'(bus.out_valid), 0);
        check("wait_hold_x5", bus.cm_x[5], base + 5);
        check("wait_hold_start", 32'(bus.cm_start), exp_start);
    endtask

    task automatic drain(input int base, input int stall_at, input int n_xfer,
                         input logic exp_fd);
        tick();
        check("first_out_valid", 32'(bus.out_valid), 1);
        for (int j = 0; j < n_xfer; j++) begin
            check("out_re", bus.out_re, base + j + 100);
            check("out_im", bus.out_im, -(base + j) - 100);
            if (j == stall_at) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    spur = (s == 0);
                    tick();
                    spur = 1'b0;
                    check("stall_re", bus.out_re, base + j + 100);
                    check("stall_im", bus.out_im, -(base + j) - 100);
                    check("stall_in_ready", 32'(bus.in_ready), 0);
                end
                bus.out_ready = 1'b1;
            end
            if (j < 7) check("mid_frame_done", 32'(bus.frame_done), 0);
            tick();
        end
        if (n_xfer == 8) begin
            check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
            check("end_out_valid", 32'(bus.out_valid), 0);
            check("end_in_ready", 32'(bus.in_ready), 1);
        end
    endtask

    initial begin
        int n;
        bus.cfg_step  = 6'd3;
        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            y_reg[i]  = '0;
            yi_reg[i] = '0;
        end

        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_cm_isValid", 32'(bus.cm_isValid), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_cm_start", 32'(bus.cm_start), 0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(bus.in_ready), 1);

        // Frame A: step 3 latched at block 0, cfg_step changes mid-frame.
        for (int b = 0; b < NB; b++) begin
            feed(b * 8, ((b * 3) % 8) * 8, 3);
            if (b == 0) bus.cfg_step = 6'd5;
            drain(b * 8, (b == 2) ? 2 : -1, 8, (b == NB - 1));
        end

        // Frame B: step 5 now takes effect.
        feed(200, 0, 5);
        drain(200, -1, 8, 1'b0);

        mul_en = 1'b0;
        feed(300, 40, 5);
        n = 1;
        while (bus.err !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, TO + 1);
        check("timeout_err", 32'(bus.err), 1);
        check("timeout_in_ready", 32'(bus.in_ready), 1);
        check("timeout_out_valid", 32'(bus.out_valid), 0);
        mul_en = 1'b1;

        feed(310, 40, 5);
        drain(310, -1, 8, 1'b0);
        check("err_sticky", 32'(bus.err), 1);

        feed(400, 16, 5);
        drain(400, -1, 3, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 0);
        check("midrst_cm_isValid", 32'(bus.cm_isValid), 0);
        check("midrst_err", 32'(bus.err), 0);
        check("midrst_in_ready", 32'(bus.in_ready), 0);
        check("midrst_out_re", bus.out_re, 0);
        check("midrst_cm_step", 32'(bus.cm_step), 0);
        tick();
        rst = 1'b0;
        tick();
        check("midrst_in_ready_after", 32'(bus.in_ready), 1);

        bus.cfg_step = 6'd1;
        feed(500, 0, 1);
        drain(500, -1, 8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
